// File: rtl/tmdma.sv
// rtl/tmdma.sv - Unibus byte DMA engine with 16-byte ARM-side FIFO and bus master sequencer.
// Optional NXM timeout in MSYN enabled by defining TMDMA_NXMTIMEOUT_EN.
module tmdma #(
  parameter int TMOCYC = 1023
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        start,
  input  logic        abort,
  input  logic        dir,
  input  logic [17:0] startaddr,
  input  logic [15:0] bytecount,
  output logic        busy,
  output logic        done,
  output logic        nxm,
  output logic [17:0] curaddr,
  output logic [16:0] remain,
  input  logic        fifo_wen,
  input  logic [7:0]  fifo_wdata,
  input  logic        fifo_ren,
  output logic [7:0]  fifo_rdata,
  output logic [4:0]  fifo_count,
  output logic        dmareq,
  input  logic        dmagnt,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        msyn_out_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SETUP, S_MSYN, S_WAITOFF, S_DONE} state_t;

  state_t      state;
  logic        dir_q, abort_pend, setup_cnt, done_q;
  logic [17:0] curaddr_q;
  logic [16:0] remain_q;

  logic [7:0]  fifo_mem [16];
  logic [3:0]  wptr, rptr;
  logic [4:0]  cnt;
  logic        fifo_full, fifo_empty, req_ok;
  logic        eng_pop, eng_push, arm_push, arm_pop, do_push, do_pop;
  logic [7:0]  push_data;

  if (TMOCYC < 1) begin : g_tmocyc_invalid
  end

  assign fifo_full  = (cnt == 5'd16);
  assign fifo_empty = (cnt == 5'd0);
  assign fifo_rdata = fifo_mem[rptr];
  assign fifo_count = cnt;

  // Only ask for the bus when the next byte can actually be moved.
  assign req_ok   = dir_q ? !fifo_full : !fifo_empty;
  assign dmareq   = (state == S_REQ) && req_ok && !abort_pend;
  assign eng_pop  = (state == S_REQ) && !dir_q && !fifo_empty && dmagnt && !abort_pend && !abort;
  assign eng_push = (state == S_MSYN) && dir_q && ssyn_in_h;

  assign arm_push  = fifo_wen && !fifo_full && !eng_push;
  assign arm_pop   = fifo_ren && !fifo_empty && !eng_pop;
  assign do_push   = arm_push || (eng_push && !fifo_full);
  assign do_pop    = arm_pop || eng_pop;
  assign push_data = eng_push ? (curaddr_q[0] ? d_in_h[15:8] : d_in_h[7:0]) : fifo_wdata;

  always_ff @(posedge CLOCK) begin
    if (do_push) fifo_mem[wptr] <= push_data;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 4'd1;
      if (do_pop)  rptr <= rptr + 4'd1;
      cnt <= cnt + 5'(do_push) - 5'(do_pop);
    end
  end

`ifdef TMDMA_NXMTIMEOUT_EN
  localparam int TW = $clog2(TMOCYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          nxm_q;
  assign nxm = nxm_q;
`else
  assign nxm = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      dir_q      <= 1'b0;
      abort_pend <= 1'b0;
      setup_cnt  <= 1'b0;
      done_q     <= 1'b0;
      curaddr_q  <= '0;
      remain_q   <= '0;
      a_out_h    <= '0;
      c_out_h    <= '0;
      d_out_h    <= '0;
      msyn_out_h <= 1'b0;
`ifdef TMDMA_NXMTIMEOUT_EN
      tmo_cnt    <= '0;
      nxm_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort && state != S_IDLE) abort_pend <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          state      <= S_REQ;
          dir_q      <= dir;
          curaddr_q  <= startaddr;
          remain_q   <= (bytecount == 16'd0) ? 17'h10000 : {1'b0, bytecount};
          abort_pend <= 1'b0;
`ifdef TMDMA_NXMTIMEOUT_EN
          nxm_q      <= 1'b0;
`endif
        end
        S_REQ: if (abort_pend || abort) begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end else if (dmagnt && req_ok) begin
          state     <= S_SETUP;
          setup_cnt <= 1'b0;
          a_out_h   <= dir_q ? {curaddr_q[17:1], 1'b0} : curaddr_q;
          c_out_h   <= dir_q ? 2'd0 : 2'd3;
          d_out_h   <= dir_q ? 16'h0 : {fifo_rdata, fifo_rdata};
        end
        S_SETUP: if (setup_cnt) begin
          state      <= S_MSYN;
          msyn_out_h <= 1'b1;
`ifdef TMDMA_NXMTIMEOUT_EN
          tmo_cnt    <= '0;
`endif
        end else begin
          setup_cnt <= 1'b1;
        end
        S_MSYN: if (ssyn_in_h) begin
          state      <= S_WAITOFF;
          msyn_out_h <= 1'b0;
        end
`ifdef TMDMA_NXMTIMEOUT_EN
        else if (tmo_cnt == TW'(TMOCYC - 1)) begin
          state      <= S_DONE;
          done_q     <= 1'b1;
          nxm_q      <= 1'b1;
          msyn_out_h <= 1'b0;
          a_out_h    <= '0;
          c_out_h    <= '0;
          d_out_h    <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
`endif
        S_WAITOFF: if (!ssyn_in_h) begin
          curaddr_q <= curaddr_q + 18'd1;
          remain_q  <= remain_q - 17'd1;
          a_out_h   <= '0;
          c_out_h   <= '0;
          d_out_h   <= '0;
          if (remain_q == 17'd1 || abort_pend || abort) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state <= S_REQ;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = done_q;
  assign curaddr = curaddr_q;
  assign remain  = remain_q;
endmodule

// File: tb/tb_tmdma.sv
// tb/tb_tmdma.sv - Directed bench for tmdma: FIFO vector table plus Unibus DMA sequences.
module tb_tmdma;
  logic        CLOCK = 1'b0, RESET = 1'b1;
  logic        start = 1'b0, abort = 1'b0, dir = 1'b0;
  logic [17:0] startaddr = '0;
  logic [15:0] bytecount = '0;
  logic        busy, done, nxm, dmareq, msyn_out_h;
  logic [17:0] curaddr, a_out_h;
  logic [16:0] remain;
  logic        fifo_wen = 1'b0, fifo_ren = 1'b0;
  logic [7:0]  fifo_wdata = '0, fifo_rdata;
  logic [4:0]  fifo_count;
  logic        dmagnt = 1'b0, ssyn_in_h = 1'b0;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h, d_in_h = '0;

  tmdma #(.TMOCYC(1023)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .abort(abort), .dir(dir),
    .startaddr(startaddr), .bytecount(bytecount), .busy(busy), .done(done), .nxm(nxm),
    .curaddr(curaddr), .remain(remain), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata), .fifo_count(fifo_count),
    .dmareq(dmareq), .dmagnt(dmagnt), .a_out_h(a_out_h), .c_out_h(c_out_h),
    .d_out_h(d_out_h), .msyn_out_h(msyn_out_h), .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct { logic [1:0] c; logic [17:0] a; logic [7:0] b; } bus_rec_t;
  typedef struct {
    logic wen; logic [7:0] wdata; logic ren;
    logic [4:0] exp_count; logic chk_head; logic [7:0] exp_head;
  } fvec_t;

  int          tests = 0, fails = 0;
  logic [15:0] mem [int];
  bus_rec_t    log_q [$];
  int          msyn_cnt = 0, viol = 0, dly = 0;
  int          ack_delay = 1;
  bit          silent = 1'b0;
  logic [17:0] d_curaddr;
  logic [16:0] d_remain;
  logic        d_nxm, d_bus;

  // Unibus slave model plus grant and request-qualification monitor.
  always @(negedge CLOCK) begin
    dmagnt = dmareq;
    if (msyn_out_h) msyn_cnt++;
    if (dmareq && ((!dir && fifo_count == 5'd0) || (dir && fifo_count == 5'd16))) viol++;
    if (RESET) begin
      ssyn_in_h = 1'b0;
      dly = 0;
    end else if (msyn_out_h && !ssyn_in_h && !silent) begin
      if (dly >= ack_delay) begin
        d_in_h = mem.exists(int'(a_out_h[17:1])) ? mem[int'(a_out_h[17:1])] : 16'h0;
        log_q.push_back('{c: c_out_h, a: a_out_h, b: d_out_h[7:0]});
        if (c_out_h == 2'd3 && d_out_h[15:8] != d_out_h[7:0]) viol++;
        ssyn_in_h = 1'b1;
        dly = 0;
      end else dly++;
    end else if (!msyn_out_h && ssyn_in_h) begin
      ssyn_in_h = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK); RESET = 1'b1;
    @(negedge CLOCK); RESET = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge CLOCK); fifo_wen = 1'b1; fifo_wdata = b;
    @(negedge CLOCK); fifo_wen = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    @(negedge CLOCK); chk(name, fifo_rdata, exp); fifo_ren = 1'b1;
    @(negedge CLOCK); fifo_ren = 1'b0;
  endtask

  task automatic go(input logic d, input logic [17:0] sa, input logic [15:0] bc);
    @(negedge CLOCK); dir = d; startaddr = sa; bytecount = bc; start = 1'b1;
    @(negedge CLOCK); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge CLOCK);
      if (done) begin
        ok = 1'b1;
        d_curaddr = curaddr; d_remain = remain; d_nxm = nxm;
        d_bus = (a_out_h != 0) || (c_out_h != 0) || (d_out_h != 0) || msyn_out_h || dmareq;
      end
    end
    chk({name, "_done_seen"}, 32'(ok), 32'd1);
    @(negedge CLOCK);
    chk({name, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
  endtask

  task automatic wait_msyn(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLOCK);
      ok = msyn_out_h;
    end
    chk({name, "_msyn_seen"}, 32'(ok), 32'd1);
  endtask

  initial begin
    fvec_t vecs[25];
    int base, vbase, mbase;
    vecs[0] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'hA1, 1'b0, 5'd1, 1'b1, 8'hA1};
    vecs[2] = '{1'b1, 8'hB2, 1'b0, 5'd2, 1'b1, 8'hA1};
    vecs[3] = '{1'b1, 8'hC3, 1'b1, 5'd2, 1'b1, 8'hB2};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'hC3};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 8'hD4, 1'b1, 5'd1, 1'b1, 8'hD4};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
    for (int i = 0; i < 16; i++)
      vecs[8+i] = '{1'b1, 8'h40 + 8'(i), 1'b0, 5'(i + 1), 1'b1, 8'h40};
    vecs[24] = '{1'b1, 8'hEE, 1'b0, 5'd16, 1'b1, 8'h40};

    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("reset_state", {busy, done, nxm, dmareq, msyn_out_h}, 32'd0);
    chk("reset_bus", {a_out_h, c_out_h} | 32'(d_out_h), 32'd0);
    chk("reset_addr_remain", 32'(curaddr) | 32'(remain), 32'd0);
    chk("reset_fifo", 32'(fifo_count), 32'd0);

    for (int i = 0; i < 25; i++) begin
      @(negedge CLOCK);
      fifo_wen = vecs[i].wen; fifo_wdata = vecs[i].wdata; fifo_ren = vecs[i].ren;
      @(posedge CLOCK); #1;
      fifo_wen = 1'b0; fifo_ren = 1'b0;
      chk($sformatf("fifo_vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      if (vecs[i].chk_head) chk($sformatf("fifo_vec%0d_head", i), 32'(fifo_rdata), 32'(vecs[i].exp_head));
    end
    for (int k = 0; k < 16; k++) pop_chk($sformatf("fifo_drain%0d", k), 8'h40 + 8'(k));
    chk("fifo_drained", 32'(fifo_count), 32'd0);

    // Tape read: three DATOB byte writes.
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    base = log_q.size(); vbase = viol;
    go(1'b0, 18'o1000, 16'd3);
    wait_done("datob", 200);
    chk("datob_count", 32'(log_q.size() - base), 32'd3);
    for (int i = 0; i < 3 && base + i < log_q.size(); i++)
      chk($sformatf("datob_rec%0d", i), {log_q[base+i].c, log_q[base+i].a, log_q[base+i].b},
          {2'd3, 18'o1000 + 18'(i), 8'h11 * 8'(i + 1)});
    chk("datob_remain", 32'(d_remain), 32'd0);
    chk("datob_curaddr", 32'(d_curaddr), 32'o1003);
    chk("datob_bus_idle_at_done", 32'(d_bus), 32'd0);
    chk("datob_viol", 32'(viol - vbase), 32'd0);

    // Tape write: odd then even address byte lanes.
    do_reset();
    mem[int'(18'o2000 >> 1)] = 16'hAB12;
    mem[int'(18'o2002 >> 1)] = 16'h34CD;
    base = log_q.size();
    go(1'b1, 18'o2001, 16'd2);
    wait_done("dati", 200);
    chk("dati_count", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() >= base + 2) begin
      chk("dati_addr0", {log_q[base].c, log_q[base].a}, {2'd0, 18'o2000});
      chk("dati_addr1", {log_q[base+1].c, log_q[base+1].a}, {2'd0, 18'o2002});
    end
    chk("dati_fifo_count", 32'(fifo_count), 32'd2);
    pop_chk("dati_byte0", 8'hAB);
    pop_chk("dati_byte1", 8'hCD);

    // Slow ARM refill: engine must idle while the FIFO is empty.
    do_reset();
    base = log_q.size(); vbase = viol;
    go(1'b0, 18'o3000, 16'd20);
    fork
      for (int i = 0; i < 20; i++) begin
        repeat (7) @(negedge CLOCK);
        fifo_wen = 1'b1; fifo_wdata = 8'h80 + 8'(i);
        @(negedge CLOCK); fifo_wen = 1'b0;
      end
      wait_done("slow", 3000);
    join
    chk("slow_count", 32'(log_q.size() - base), 32'd20);
    for (int i = 0; i < 20 && base + i < log_q.size(); i++)
      chk($sformatf("slow_rec%0d", i), {log_q[base+i].a, log_q[base+i].b},
          {18'o3000 + 18'(i), 8'h80 + 8'(i)});
    chk("slow_dmareq_viol", 32'(viol - vbase), 32'd0);
    chk("slow_curaddr", 32'(d_curaddr), 32'o3024);

    // Abort mid-MSYN completes the cycle then stops.
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    ack_delay = 4;
    base = log_q.size();
    go(1'b0, 18'o100, 16'd5);
    wait_msyn("abort");
    @(negedge CLOCK); abort = 1'b1;
    @(negedge CLOCK); abort = 1'b0;
    chk("abort_msyn_held", 32'(msyn_out_h), 32'd1);
    wait_done("abort", 100);
    chk("abort_count", 32'(log_q.size() - base), 32'd1);
    chk("abort_remain", 32'(d_remain), 32'd4);
    chk("abort_curaddr", 32'(d_curaddr), 32'o101);
    chk("abort_fifo", 32'(fifo_count), 32'd4);
    ack_delay = 1;

    // Address wrap at 2^18.
    do_reset();
    push(8'hAA); push(8'hBB);
    base = log_q.size();
    go(1'b0, 18'o777777, 16'd2);
    wait_done("wrap", 200);
    chk("wrap_count", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() >= base + 2) begin
      chk("wrap_rec0", {log_q[base].a, log_q[base].b}, {18'o777777, 8'hAA});
      chk("wrap_rec1", {log_q[base+1].a, log_q[base+1].b}, {18'o0, 8'hBB});
    end
    chk("wrap_curaddr", 32'(d_curaddr), 32'd1);

    // Silent responder, then RESET while msyn is asserted.
    do_reset();
    silent = 1'b1;
    push(8'h77); push(8'h78);
    go(1'b0, 18'o4000, 16'd2);
    wait_msyn("rst");
    repeat (50) @(negedge CLOCK);
    chk("rst_msyn_waiting", {29'd0, msyn_out_h, nxm, busy}, {29'd0, 3'b101});
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    chk("rst_bus_cleared", {msyn_out_h, busy, dmareq, c_out_h, a_out_h}, 32'd0);
    chk("rst_regs_cleared", 32'(curaddr) | 32'(remain) | 32'(fifo_count) | 32'(d_out_h), 32'd0);
    @(negedge CLOCK); RESET = 1'b0;

`ifdef TMDMA_NXMTIMEOUT_EN
    push(8'h99);
    mbase = msyn_cnt;
    go(1'b0, 18'o5000, 16'd1);
    wait_done("nxm", 1300);
    chk("nxm_set", 32'(d_nxm), 32'd1);
    chk("nxm_msyn_cycles", 32'(msyn_cnt - mbase), 32'd1023);
    chk("nxm_bus_idle", 32'(d_bus), 32'd0);
    chk("nxm_sticky", 32'(nxm), 32'd1);
`else
    mbase = msyn_cnt;
    chk("nxm_absent", 32'(nxm), 32'd0);
`endif
    silent = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
